// File: rtl/W5300.sv
// W5300 register-access constants shared by the access scheduler.
// Contents: bus widths, WR/RD op encoding, ID register address/value,
// power-up init table, command-kind and scheduler-state enums, command
// payload struct, and helpers for building filler commands and reading
// table entries.
package W5300;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = ADDR_W + 1;

    // Op bit in ctrl_addr[10]
    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    localparam logic [ADDR_W-1:0] IDR_ADDR  = 10'h3FE;
    localparam logic [DATA_W-1:0] IDR_VALUE = 16'h5300;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } init_entry_t;

    localparam int unsigned INIT_LEN = 3;

    // Register writes issued in order once the chip ID has been confirmed
    localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
        '{addr: 10'h000, data: 16'h3800},
        '{addr: 10'h020, data: 16'h0808},
        '{addr: 10'h028, data: 16'h0404}
    };

    localparam int unsigned TBL_IW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

    typedef enum logic [2:0] {
        NONE,
        ID,
        INIT,
        FILL,
        REQ0,
        REQ1
    } cmd_kind_t;

    typedef enum logic [2:0] {
        S_WAIT_IF,
        S_CHECK_ID,
        S_INIT,
        S_SERVE,
        S_ERROR
    } sched_state_t;

    typedef struct packed {
        cmd_kind_t         kind;
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // ID-register read; used both as the ID probe and as the idle filler
    function automatic cmd_t filler_cmd(input cmd_kind_t kind);
        cmd_t c;
        c.kind = kind;
        c.op   = RD;
        c.addr = IDR_ADDR;
        c.data = '0;
        return c;
    endfunction

    function automatic init_entry_t init_entry(input logic [TBL_IW-1:0] i);
        return INIT_TABLE[i];
    endfunction

endpackage

// File: rtl/w5300_rr_arb2.sv
// Two-port round-robin arbiter.
// Ports: clk, rst_n      - clock, async active-low reset
//        req[1:0]        - request vector (bit k = port k valid)
//        advance         - a grant is being taken this cycle
//        grant_c[1:0]    - one-hot combinational grant
// The pointer names the preferred port when both request; it moves to the
// other port after every taken grant.
module w5300_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant_c
);

    logic ptr;

    // Lone requester wins regardless of pointer
    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = ptr ? 2'b10 : 2'b01;
            default: grant_c = 2'b00;
        endcase
    end

    // Point at the port that was not just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance && (|req)) begin
            ptr <= grant_c[0];
        end
    end

endmodule

// File: rtl/w5300_access_sched.sv
// W5300 register-access scheduler.
// Sequences ID check and init-table writes after reset, then shares the
// interface block between two request ports by round robin.
// Ports: clk, rst_n                  - clock, async active-low reset
//        ctrl_addr/ctrl_wr_data      - command to interface block ([10]=op)
//        ctrl_rd_data                - read result, valid in slot cycles
//        ctrl_op_state               - 1 = interface idle (slot cycle)
//        reqK_valid/we/addr/wdata    - request channel K (K=0,1)
//        reqK_ready                  - combinational grant for port K
//        rspK_valid/rspK_rdata       - one-cycle completion pulse
//        init_done/init_error        - Serve reached / ID check failed
// INIT_LEN must not exceed the package table length.
module w5300_access_sched #(
    parameter int unsigned INIT_LEN   = W5300::INIT_LEN,
    parameter int unsigned ID_RETRIES = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [W5300::CMD_W-1:0]    ctrl_addr,
    output logic [W5300::DATA_W-1:0]   ctrl_wr_data,
    input  logic [W5300::DATA_W-1:0]   ctrl_rd_data,
    input  logic                       ctrl_op_state,
    input  logic                       req0_valid,
    input  logic                       req0_we,
    input  logic [W5300::ADDR_W-1:0]   req0_addr,
    input  logic [W5300::DATA_W-1:0]   req0_wdata,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic                       req1_we,
    input  logic [W5300::ADDR_W-1:0]   req1_addr,
    input  logic [W5300::DATA_W-1:0]   req1_wdata,
    output logic                       req1_ready,
    output logic                       rsp0_valid,
    output logic [W5300::DATA_W-1:0]   rsp0_rdata,
    output logic                       rsp1_valid,
    output logic [W5300::DATA_W-1:0]   rsp1_rdata,
    output logic                       init_done,
    output logic                       init_error
);

    import W5300::*;

    localparam int unsigned IDX_W = (INIT_LEN > 0) ? $clog2(INIT_LEN + 1) : 1;
    localparam int unsigned ATT_W = (ID_RETRIES > 0) ? $clog2(ID_RETRIES + 1) : 1;

    sched_state_t      state;
    sched_state_t      state_nxt;
    sched_state_t      state_eff;
    cmd_t              cur_cmd;
    cmd_t              cmd_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [ATT_W-1:0]  att;
    logic [ATT_W-1:0]  att_nxt;
    logic              arb_en;
    logic              slot;
    logic [1:0]        grant_c;
    init_entry_t       init_ent;

    assign slot     = ctrl_op_state;
    assign init_ent = init_entry(TBL_IW'(idx));

    w5300_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (slot && arb_en),
        .grant_c (grant_c)
    );

    // Next command / next state, evaluated every cycle, committed on slots
    always_comb begin
        state_nxt = state;
        cmd_nxt   = filler_cmd(FILL);
        idx_nxt   = idx;
        att_nxt   = att;
        arb_en    = 1'b0;
        case (state)
            S_WAIT_IF: begin
                cmd_nxt   = filler_cmd(ID);
                att_nxt   = ATT_W'(1);
                state_nxt = S_CHECK_ID;
            end
            S_CHECK_ID: begin
                if (ctrl_rd_data == IDR_VALUE) begin
                    if (INIT_LEN == 0) begin
                        arb_en    = 1'b1;
                        state_nxt = S_SERVE;
                    end else begin
                        cmd_nxt   = '{kind: INIT, op: WR, addr: init_ent.addr, data: init_ent.data};
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = S_INIT;
                    end
                end else if (att < ATT_W'(ID_RETRIES)) begin
                    cmd_nxt = filler_cmd(ID);
                    att_nxt = att + ATT_W'(1);
                end else begin
                    state_nxt = S_ERROR;
                end
            end
            S_INIT: begin
                // idx == INIT_LEN means this slot retires the last table entry
                if (idx == IDX_W'(INIT_LEN)) begin
                    arb_en    = 1'b1;
                    state_nxt = S_SERVE;
                end else begin
                    cmd_nxt = '{kind: INIT, op: WR, addr: init_ent.addr, data: init_ent.data};
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            S_SERVE: begin
                arb_en = 1'b1;
            end
            S_ERROR: begin
                state_nxt = S_ERROR;
            end
            default: begin
                state_nxt = S_WAIT_IF;
            end
        endcase
        if (arb_en) begin
            if (grant_c[0]) begin
                cmd_nxt = '{kind: REQ0, op: (req0_we ? WR : RD), addr: req0_addr, data: req0_wdata};
            end else if (grant_c[1]) begin
                cmd_nxt = '{kind: REQ1, op: (req1_we ? WR : RD), addr: req1_addr, data: req1_wdata};
            end
        end
    end

    assign state_eff = slot ? state_nxt : state;

    // Slot cycles present the command about to start; otherwise the running one
    assign ctrl_addr    = slot ? {cmd_nxt.op, cmd_nxt.addr} : {cur_cmd.op, cur_cmd.addr};
    assign ctrl_wr_data = slot ? cmd_nxt.data : cur_cmd.data;

    assign req0_ready = slot && arb_en && grant_c[0];
    assign req1_ready = slot && arb_en && grant_c[1];

    // State, command pipeline, responses and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT_IF;
            cur_cmd    <= filler_cmd(NONE);
            idx        <= '0;
            att        <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (slot) begin
                state   <= state_nxt;
                cur_cmd <= cmd_nxt;
                idx     <= idx_nxt;
                att     <= att_nxt;
                // Slot retires cur_cmd; read data for it is on ctrl_rd_data now
                if (cur_cmd.kind == REQ0) begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= (cur_cmd.op == WR) ? '0 : ctrl_rd_data;
                end
                if (cur_cmd.kind == REQ1) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= (cur_cmd.op == WR) ? '0 : ctrl_rd_data;
                end
            end
            init_done  <= (state_eff == S_SERVE);
            init_error <= init_error | (state_eff == S_ERROR);
        end
    end

endmodule
